// File: rtl/multi_operand_adder.sv
// Two-stage multi-operand unsigned adder: a 3:2 carry-save tree feeds a registered sum/carry pair, and a final add produces the result.
// Defining ADDER_SAT_EN makes the result saturate at 2^OW-1 on overflow; left undefined, the result wraps modulo 2^OW.
module multi_operand_adder #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 3,
    parameter int unsigned OW = W + 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_ops,
    input  logic           in_acc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  out_sum,
    output logic           out_ovf
);

    function automatic int unsigned rows_after(input int unsigned n, input int unsigned lv);
        int unsigned c;
        c = n;
        for (int unsigned i = 0; i < lv; i++)
            if (c > 2) c = 2 * (c / 3) + c % 3;
        return c;
    endfunction

    function automatic int unsigned tree_depth(input int unsigned n);
        int unsigned c;
        int unsigned d;
        c = n;
        d = 0;
        while (c > 2) begin
            c = 2 * (c / 3) + c % 3;
            d++;
        end
        return d;
    endfunction

    localparam int unsigned DEPTH = tree_depth(N);

    logic [OW-1:0] rows [DEPTH+1][N];

    for (genvar j = 0; j < N; j++) begin : g_load
        assign rows[0][j] = OW'(in_ops[j*W +: W]);
    end

    // Each level packs 3:2 outputs first, then passes leftover rows through.
    // Rows never exceed the true total, so the carry shift cannot drop a set bit.
    for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
        localparam int unsigned C = rows_after(N, l);
        localparam int unsigned G = C / 3;
        for (genvar j = 0; j < N; j++) begin : g_row
            if (j < 2 * G) begin : g_csa
                localparam int unsigned B = 3 * (j / 2);
                if (j % 2 == 0) begin : g_s
                    assign rows[l+1][j] = rows[l][B] ^ rows[l][B+1] ^ rows[l][B+2];
                end else begin : g_c
                    assign rows[l+1][j] = ((rows[l][B] & rows[l][B+1]) |
                                           (rows[l][B] & rows[l][B+2]) |
                                           (rows[l][B+1] & rows[l][B+2])) << 1;
                end
            end else if (j < 2 * G + C % 3) begin : g_pass
                assign rows[l+1][j] = rows[l][j + G];
            end else begin : g_zero
                assign rows[l+1][j] = '0;
            end
        end
    end

    logic          s1_valid;
    logic [OW-1:0] s1_sum;
    logic [OW-1:0] s1_carry;
    logic          s1_acc;
    logic [OW-1:0] acc;
    logic          s2_adv;
    logic [OW+1:0] s2_total;
    logic          s2_ovf;
    logic [OW-1:0] s2_res;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_acc   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= rows[DEPTH][0];
                s1_carry <= rows[DEPTH][1];
                s1_acc   <= in_acc;
            end
        end
    end

    always_comb begin
        s2_total = {2'b00, s1_sum} + {2'b00, s1_carry} + (s1_acc ? {2'b00, acc} : '0);
        s2_ovf   = |s2_total[OW+1:OW];
`ifdef ADDER_SAT_EN
        s2_res   = s2_ovf ? '1 : s2_total[OW-1:0];
`else
        s2_res   = s2_total[OW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= s2_res;
                out_ovf <= s2_ovf;
                acc     <= s2_res;
            end
        end
    end

endmodule

// File: tb/tb_multi_operand_adder.sv
// Self-checking bench for multi_operand_adder: directed cases, then random streams on four configurations checked against an arithmetic model.
module tb_multi_operand_adder;

`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        iv   [4];
    logic        iacc [4];
    logic        ordy [4];
    logic [63:0] ops  [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        oovf [4];
    logic [15:0] osum [4];
    logic [6:0]  osum0;
    logic [10:0] osum1;
    logic [8:0]  osum2;
    logic [10:0] osum3;

    int unsigned cw  [4] = '{5, 8, 6, 8};
    int unsigned cn  [4] = '{3, 4, 5, 8};
    int unsigned cow [4] = '{7, 11, 9, 11};

    int total = 0;
    int bad   = 0;

    assign osum[0] = 16'(osum0);
    assign osum[1] = 16'(osum1);
    assign osum[2] = 16'(osum2);
    assign osum[3] = 16'(osum3);

    multi_operand_adder #(.W(5), .N(3), .OW(7)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_ops(ops[0][14:0]),
        .in_acc(iacc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(osum0), .out_ovf(oovf[0]));
    multi_operand_adder #(.W(8), .N(4), .OW(11)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_ops(ops[1][31:0]),
        .in_acc(iacc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(osum1), .out_ovf(oovf[1]));
    multi_operand_adder #(.W(6), .N(5), .OW(9)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_ops(ops[2][29:0]),
        .in_acc(iacc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(osum2), .out_ovf(oovf[2]));
    multi_operand_adder #(.W(8), .N(8), .OW(11)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_ops(ops[3]),
        .in_acc(iacc[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(osum3), .out_ovf(oovf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one beat into instance 0 on an empty pipeline and checks two-edge latency.
    task automatic send0(input logic [14:0] v, input logic a, input int unsigned es,
                         input logic eo, input string tag);
        ops[0]  = 64'(v);
        iacc[0] = a;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check({tag, "_lat1"}, 64'(ov[0]), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(ov[0]), 64'd1);
        check({tag, "_sum"}, 64'(osum[0]), 64'(es));
        check({tag, "_ovf"}, 64'(oovf[0]), 64'(eo));
    endtask

    longint unsigned exp_s [4][512];
    logic            exp_o [4][512];
    int unsigned     wr [4];
    int unsigned     rd [4];
    longint unsigned macc [4];

    initial begin
        int unsigned sat_or_wrap;
        int unsigned bp_exp [6];
        int unsigned got;
        int unsigned sent;
        bit          saw_ir_low;
        longint unsigned tot;
        longint unsigned mx;

        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; iacc[i] = 1'b0; ordy[i] = 1'b1; ops[i] = '0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(ov[0]), 64'd0);
        check("rst_sum", 64'(osum[0]), 64'd0);
        check("rst_ovf", 64'(oovf[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(ir[0]), 64'd1);

        send0({5'd31, 5'd31, 5'd31}, 1'b0, 93, 1'b0, "basic");
        sat_or_wrap = SAT ? 127 : 58;
        send0({5'd31, 5'd31, 5'd31}, 1'b1, sat_or_wrap, 1'b1, "ovf");
        send0({5'd0, 5'd0, 5'd0}, 1'b1, sat_or_wrap, 1'b0, "ovf_next");

        // back-to-back accumulate: 6, 9, 12, 15 on consecutive cycles
        for (int b = 0; b < 6; b++) begin
            iv[0]   = (b < 4);
            iacc[0] = (b != 0);
            ops[0]  = (b == 0) ? 64'({5'd3, 5'd2, 5'd1}) : 64'({5'd1, 5'd1, 5'd1});
            @(posedge clk); #1;
            if (b >= 1 && b <= 4) begin
                check($sformatf("stream_valid%0d", b), 64'(ov[0]), 64'd1);
                check($sformatf("stream_sum%0d", b), 64'(osum[0]), 64'(3 + 3 * b));
            end
        end
        iv[0] = 1'b0;

        // back-pressure: six beats, consumer stalls for three cycles
        for (int k = 0; k < 6; k++) bp_exp[k] = k + 4;
        got = 0; sent = 0; saw_ir_low = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            @(negedge clk);
            ordy[0] = !(cyc >= 3 && cyc <= 5);
            iv[0]   = (sent < 6);
            iacc[0] = 1'b0;
            ops[0]  = 64'({5'd2, 5'd1, 5'(sent + 1)});
            #1;
            if (!ir[0]) saw_ir_low = 1'b1;
            if (ov[0] && got < 6) begin
                check($sformatf("bp_sum%0d", got), 64'(osum[0]), 64'(bp_exp[got]));
                if (ordy[0]) got++;
            end
            if (iv[0] && ir[0]) sent++;
        end
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        check("bp_count", 64'(got), 64'd6);
        check("bp_ready_drop", 64'(saw_ir_low), 64'd1);
        @(posedge clk); #1;
        check("bp_no_dup", 64'(ov[0]), 64'd0);

        // asynchronous reset with both stages full and acc=40
        send0({5'd10, 5'd10, 5'd20}, 1'b0, 40, 1'b0, "acc40");
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        iacc[0] = 1'b1;
        ops[0]  = 64'({5'd3, 5'd2, 5'd1});
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("full_ready", 64'(ir[0]), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(ov[0]), 64'd0);
        check("mid_rst_sum", 64'(osum[0]), 64'd0);
        check("mid_rst_ovf", 64'(oovf[0]), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        send0({5'd1, 5'd1, 5'd1}, 1'b1, 3, 1'b0, "post_rst");

        // widest configuration, all operands at maximum
        ops[3] = '1; iacc[3] = 1'b0; iv[3] = 1'b1; ordy[3] = 1'b1;
        @(posedge clk); #1;
        iv[3] = 1'b0;
        @(posedge clk); #1;
        check("sweep_valid", 64'(ov[3]), 64'd1);
        check("sweep_sum", 64'(osum[3]), 64'd2040);
        check("sweep_ovf", 64'(oovf[3]), 64'd0);

        // random streams on all four configurations
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0; rd[i] = 0; macc[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                iv[i]   = (cyc < 360) && ($urandom_range(0, 9) < 7);
                iacc[i] = ($urandom_range(0, 9) < 7);
                ordy[i] = (cyc >= 360) || ($urandom_range(0, 9) < 7);
                ops[i]  = {$urandom, $urandom};
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && ordy[i]) begin
                    if (rd[i] < wr[i]) begin
                        check($sformatf("rnd%0d_sum", i), 64'(osum[i]), exp_s[i][rd[i]]);
                        check($sformatf("rnd%0d_ovf", i), 64'(oovf[i]), 64'(exp_o[i][rd[i]]));
                        rd[i]++;
                    end else begin
                        check($sformatf("rnd%0d_spurious", i), 64'(ov[i]), 64'd0);
                    end
                end
                if (iv[i] && ir[i] && wr[i] < 512) begin
                    tot = 0;
                    for (int k = 0; k < int'(cn[i]); k++)
                        tot += (ops[i] >> (k * cw[i])) & ((64'd1 << cw[i]) - 1);
                    if (iacc[i]) tot += macc[i];
                    mx = (64'd1 << cow[i]) - 1;
                    exp_o[i][wr[i]] = (tot > mx);
                    if (tot > mx) tot = SAT ? mx : (tot & mx);
                    exp_s[i][wr[i]] = tot;
                    macc[i] = tot;
                    wr[i]++;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("rnd%0d_drained", i), 64'(rd[i]), 64'(wr[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_operand_adder.md
# multi_operand_adder

Pipelined, parametrised multi-operand unsigned adder with an optional running accumulator. It reduces N operands of W bits through a carry-save (3:2) compressor tree, registers the redundant sum/carry pair, and resolves it with a single carry-propagate add in a second stage. It is the streaming, back-pressured successor to the team's combinational three-input adder. It feeds datapath blocks (checksums, dot-product tails, counters) that need one result per cycle.

## Interface
Parameters:
- W, 8, operand width in bits (2..32)
- N, 3, operand count (3..8)
- OW, W+4, result/accumulator width; must satisfy OW >= W + clog2(N)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  beat present on inputs
- in_ready  out  1  block accepts beat this cycle
- in_ops  in  N*W  packed operands; operand k = in_ops[k*W +: W]
- in_acc  in  1  1: add accumulator to this beat's sum; 0: start fresh
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  OW  result
- out_ovf  out  1  true sum of this beat exceeded 2^OW-1

## Operation
- Transfer on an interface occurs when valid && ready in the same cycle.
- Stage 1 (S1) captures the accepted beat and compresses the N operands to a sum/carry pair of width OW. No carry-propagate chain is in S1. The compressor tree depth is ceil(log1.5(N/2)) levels of 3:2 cells. It also registers in_acc.
- Stage 2 (S2) adds sum + carry + (acc_sel ? acc : 0) at OW+2 bits.
  - out_ovf = any bit above OW-1 set.
  - Result handling depends on the configuration; see Configuration.
- Accumulator register acc (OW bits) loads the final out_sum value whenever S1 advances into S2. It therefore always holds the most recent result, independent of in_acc.
- The accumulator is consumed in S2, not S1. Back-to-back in_acc=1 beats need no stall, because each beat sees the result of the immediately preceding beat.
- Beat order is preserved. There is no reordering and no dropping.
- Back-pressure:
  - s2_adv = !out_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no skid buffer)
- Output data is held stable while out_valid && !out_ready.

## Timing
- Latency: a beat accepted at edge T gives out_valid at T+2 (after the 2nd rising edge) if out_ready was high throughout.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset (rst_n low, any time, including mid-stream) takes effect asynchronously:
  - s1_valid=0, out_valid=0
  - out_sum=0, out_ovf=0, acc=0
  - in_ready=1 while reset is deasserted and the pipeline is empty
  - Beats in flight are discarded.
- First beat after reset with in_acc=1 adds acc=0.
- Full pipeline stalled (out_valid && !out_ready, s1_valid=1): in_ready=0. S1 and S2 contents and acc are frozen.
- Simultaneous pop and push on a full pipeline: both transfers occur in one cycle with no bubble.

## Configuration
- Macro ADDER_SAT_EN, off by default.
- Defined: on overflow, out_sum saturates to 2^OW-1 and acc loads the saturated value; out_ovf=1.
- Undefined: out_sum wraps modulo 2^OW and acc loads the wrapped value; out_ovf still reports the carry-out.
- The macro changes only S2 result selection. Ports and latency are identical in both builds.

## Test plan
- Basic sum, W=5, N=3, OW=7, out_ready=1, reset state: ops {31,31,31}, in_acc=0.
  - out_ready high: out_sum=93, out_ovf=0, out_valid exactly 2 cycles after acceptance.
  - Checks the reset state: out_valid=0, out_sum=0, in_ready=1 before the first beat.
- Accumulate streaming: beats {1,2,3} acc=0 then {1,1,1} acc=1 ×3, back-to-back -> out_sum 6, 9, 12, 15 on consecutive cycles with no bubbles.
- Overflow, OW=7: start from acc=93, beat {31,31,31} acc=1 (true 186).
  - Without ADDER_SAT_EN: out_sum=58, out_ovf=1.
  - With it: out_sum=127, out_ovf=1.
  - Next acc=1 beat {0,0,0} returns 58 or 127 respectively.
- Back-pressure: stream 6 beats, out_ready low for 3 cycles mid-stream.
  - in_ready drops once both stages are full.
  - out_sum holds stable during the stall.
  - All 6 results arrive in order, none lost or duplicated.
- Reset mid-operation: assert rst_n low asynchronously with both stages full and acc=40.
  - Outputs zero immediately.
  - After release, beat {1,1,1} acc=1 -> out_sum=3.
- Parameter sweep: N=8, W=8, OW=11, all ops=255 -> out_sum=2040, out_ovf=0. Random stimulus is compared against a reference model for N in {3,4,5,8}.
